// File: rtl/sram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter_if
// Brief    : Requester and SRAM-controller signal bundle for sram_access_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_access_arbiter_if;
    logic        uart_req;
    logic [17:0] uart_addr;
    logic [15:0] uart_wdata;
    logic        uart_gnt;

    logic        vga_req;
    logic [17:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;

    logic        m1_req;
    logic        m1_we_n;
    logic [17:0] m1_addr;
    logic [15:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;

    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [1:0]  owner;

    modport slave (
        input  uart_req, uart_addr, uart_wdata,
        input  vga_req, vga_addr,
        input  m1_req, m1_we_n, m1_addr, m1_wdata,
        output uart_gnt, vga_gnt, vga_rvalid, m1_gnt, m1_rvalid,
        output SRAM_address, SRAM_write_data, SRAM_we_n, owner
    );

    modport master (
        output uart_req, uart_addr, uart_wdata,
        output vga_req, vga_addr,
        output m1_req, m1_we_n, m1_addr, m1_wdata,
        input  uart_gnt, vga_gnt, vga_rvalid, m1_gnt, m1_rvalid,
        input  SRAM_address, SRAM_write_data, SRAM_we_n, owner
    );
endinterface
`default_nettype wire

// File: rtl/sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_access_arbiter
// Brief    : Cycle-by-cycle owner of the SRAM controller port shared by UART,
//            VGA and M1, with read-valid strobes from in-flight read tags.
// Revision : 1.0 - initial release
// ============================================================================
module sram_access_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic              CLOCK_50_I,
    input  wire logic              reset,
    sram_access_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_UART = 2'd1,
        OWN_VGA  = 2'd2,
        OWN_M1   = 2'd3
    } state_t;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_TAG_NONE   = 2'd0;
    localparam logic [1:0] c_TAG_VGA    = 2'd1;
    localparam logic [1:0] c_TAG_M1     = 2'd2;
    localparam int         c_TAG_BITS   = 2 * (READ_LATENCY + 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    w_uart_gnt;
    logic                    w_vga_gnt;
    logic                    w_m1_gnt;
    logic                    w_promote;
    logic [3:0]              r_starve_cnt;
    logic [17:0]             r_address;
    logic [15:0]             r_write_data;
    logic                    r_we_n;
    logic [1:0]              w_tag_in;
    logic [1:0]              w_tag_out;
    logic [c_TAG_BITS-1:0]   r_tag_sr;

    assign w_promote = bus.m1_req && (r_starve_cnt == c_STARVE_MAX);

    // Grant decode doubles as next-state: the owner register is the grant, delayed.
    always_comb begin
        w_next_state = IDLE;
        w_uart_gnt   = 1'b0;
        w_vga_gnt    = 1'b0;
        w_m1_gnt     = 1'b0;
        w_tag_in     = c_TAG_NONE;
        if (bus.uart_req) begin
            w_uart_gnt   = 1'b1;
            w_next_state = OWN_UART;
        end else if (w_promote || (bus.m1_req && !bus.vga_req)) begin
            w_m1_gnt     = 1'b1;
            w_next_state = OWN_M1;
            w_tag_in     = bus.m1_we_n ? c_TAG_M1 : c_TAG_NONE;
        end else if (bus.vga_req) begin
            w_vga_gnt    = 1'b1;
            w_next_state = OWN_VGA;
            w_tag_in     = c_TAG_VGA;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.m1_req || w_m1_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Address and write data hold through idle cycles; only we_n is forced inactive.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_address    <= 18'd0;
            r_write_data <= 16'd0;
            r_we_n       <= 1'b1;
        end else begin
            case (w_next_state)
                OWN_UART: begin
                    r_address    <= bus.uart_addr;
                    r_write_data <= bus.uart_wdata;
                    r_we_n       <= 1'b0;
                end
                OWN_VGA: begin
                    r_address    <= bus.vga_addr;
                    r_we_n       <= 1'b1;
                end
                OWN_M1: begin
                    r_address    <= bus.m1_addr;
                    r_write_data <= bus.m1_wdata;
                    r_we_n       <= bus.m1_we_n;
                end
                default: begin
                    r_we_n       <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            r_tag_sr <= '0;
        end else begin
            r_tag_sr <= {r_tag_sr[c_TAG_BITS-3:0], w_tag_in};
        end
    end

    assign w_tag_out = r_tag_sr[c_TAG_BITS-1 -: 2];

    assign bus.uart_gnt        = w_uart_gnt;
    assign bus.vga_gnt         = w_vga_gnt;
    assign bus.m1_gnt          = w_m1_gnt;
    assign bus.vga_rvalid      = (w_tag_out == c_TAG_VGA);
    assign bus.m1_rvalid       = (w_tag_out == c_TAG_M1);
    assign bus.SRAM_address    = r_address;
    assign bus.SRAM_write_data = r_write_data;
    assign bus.SRAM_we_n       = r_we_n;
    assign bus.owner           = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_arbiter
// Brief    : Directed, table-driven self-checking bench for sram_access_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_access_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(
        .READ_LATENCY (2),
        .STARVE_LIMIT (8)
    ) u_dut (
        .CLOCK_50_I (clk),
        .reset      (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ureq;
        logic [17:0] uaddr;
        logic [15:0] udata;
        logic        vreq;
        logic [17:0] vaddr;
        logic        mreq;
        logic        mwe_n;
        logic [17:0] maddr;
        logic [15:0] mdata;
        logic [2:0]  gnt;     // {uart, vga, m1}
        logic        we_n;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  owner;
        logic [1:0]  rv;      // {vga, m1}
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] gnt, input logic we_n,
                             input logic [17:0] addr, input logic [15:0] wdata,
                             input logic [1:0] owner, input logic [1:0] rv);
        check({tag, " gnt"},   {29'd0, bus.uart_gnt, bus.vga_gnt, bus.m1_gnt}, {29'd0, gnt});
        check({tag, " we_n"},  {31'd0, bus.SRAM_we_n}, {31'd0, we_n});
        check({tag, " addr"},  {14'd0, bus.SRAM_address}, {14'd0, addr});
        check({tag, " wdata"}, {16'd0, bus.SRAM_write_data}, {16'd0, wdata});
        check({tag, " owner"}, {30'd0, bus.owner}, {30'd0, owner});
        check({tag, " rvalid"}, {30'd0, bus.vga_rvalid, bus.m1_rvalid}, {30'd0, rv});
    endtask

    task automatic drive(input vec_t v);
        bus.uart_req   = v.ureq;
        bus.uart_addr  = v.uaddr;
        bus.uart_wdata = v.udata;
        bus.vga_req    = v.vreq;
        bus.vga_addr   = v.vaddr;
        bus.m1_req     = v.mreq;
        bus.m1_we_n    = v.mwe_n;
        bus.m1_addr    = v.maddr;
        bus.m1_wdata   = v.mdata;
    endtask

    task automatic idle_inputs();
        bus.uart_req = 1'b0;
        bus.vga_req  = 1'b0;
        bus.m1_req   = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // UART beats VGA/M1, then VGA burst 100..102, then M1 write/read of addr 5.
        vecs[0] = '{1'b1, 18'h10, 16'hABCD, 1'b1, 18'h100, 1'b1, 1'b1, 18'h5, 16'h0000, 3'b100, 1'b1, 18'h0,   16'h0000, 2'd0, 2'b00};
        vecs[1] = '{1'b0, 18'h0,  16'h0000, 1'b1, 18'h100, 1'b1, 1'b1, 18'h5, 16'h0000, 3'b010, 1'b0, 18'h10,  16'hABCD, 2'd1, 2'b00};
        vecs[2] = '{1'b0, 18'h0,  16'h0000, 1'b1, 18'h101, 1'b1, 1'b1, 18'h5, 16'h0000, 3'b010, 1'b1, 18'h100, 16'hABCD, 2'd2, 2'b00};
        vecs[3] = '{1'b0, 18'h0,  16'h0000, 1'b1, 18'h102, 1'b1, 1'b1, 18'h5, 16'h0000, 3'b010, 1'b1, 18'h101, 16'hABCD, 2'd2, 2'b00};
        vecs[4] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b1, 1'b0, 18'h5, 16'h1234, 3'b001, 1'b1, 18'h102, 16'hABCD, 2'd2, 2'b10};
        vecs[5] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b1, 1'b1, 18'h5, 16'h1234, 3'b001, 1'b0, 18'h5,   16'h1234, 2'd3, 2'b10};
        vecs[6] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b0, 1'b1, 18'h0, 16'h0000, 3'b000, 1'b1, 18'h5,   16'h1234, 2'd3, 2'b10};
        vecs[7] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b0, 1'b1, 18'h0, 16'h0000, 3'b000, 1'b1, 18'h5,   16'h1234, 2'd0, 2'b00};
        vecs[8] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b0, 1'b1, 18'h0, 16'h0000, 3'b000, 1'b1, 18'h5,   16'h1234, 2'd0, 2'b01};
        vecs[9] = '{1'b0, 18'h0,  16'h0000, 1'b0, 18'h0,   1'b0, 1'b1, 18'h0, 16'h0000, 3'b000, 1'b1, 18'h5,   16'h1234, 2'd0, 2'b00};

        bus.uart_addr  = 18'd0;
        bus.uart_wdata = 16'd0;
        bus.vga_addr   = 18'd0;
        bus.m1_we_n    = 1'b1;
        bus.m1_addr    = 18'd0;
        bus.m1_wdata   = 16'd0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all($sformatf("idle[%0d]", i), 3'b000, 1'b1, 18'h0, 16'h0, 2'd0, 2'b00);
            next_cycle();
        end

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check_all($sformatf("vec[%0d]", i), vecs[i].gnt, vecs[i].we_n, vecs[i].addr,
                      vecs[i].wdata, vecs[i].owner, vecs[i].rv);
            next_cycle();
        end

        // VGA and M1 both held: eight VGA grants, then one promoted M1 grant.
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h200;
        bus.m1_req   = 1'b1;
        bus.m1_we_n  = 1'b1;
        bus.m1_addr  = 18'h300;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            check($sformatf("starve[%0d] m1_gnt", i), {31'd0, bus.m1_gnt}, {31'd0, (i % 9) == 8});
            check($sformatf("starve[%0d] vga_gnt", i), {31'd0, bus.vga_gnt}, {31'd0, (i % 9) != 8});
            next_cycle();
        end

        idle_inputs();
        next_cycle();

        // Counter must saturate at the limit while UART blocks M1 for longer.
        bus.uart_req = 1'b1;
        bus.m1_req   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("uart_block[%0d] uart_gnt", i), {31'd0, bus.uart_gnt}, 32'd1);
            next_cycle();
        end
        bus.uart_req = 1'b0;
        bus.vga_req  = 1'b1;
        @(negedge clk);
        check("saturated promote m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
        check("saturated promote vga_gnt", {31'd0, bus.vga_gnt}, 32'd0);
        next_cycle();
        @(negedge clk);
        check("post promote vga_gnt", {31'd0, bus.vga_gnt}, 32'd1);
        check("post promote m1_gnt", {31'd0, bus.m1_gnt}, 32'd0);
        next_cycle();

        idle_inputs();
        repeat (5) next_cycle();

        // Reset one cycle after a VGA read grant must kill the pending rvalid.
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h3AB;
        @(negedge clk);
        check("rst_mid vga_gnt", {31'd0, bus.vga_gnt}, 32'd1);
        next_cycle();
        bus.vga_req = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        check("rst_mid addr launched", {14'd0, bus.SRAM_address}, 32'h3AB);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_all($sformatf("after_rst[%0d]", i), 3'b000, 1'b1, 18'h0, 16'h0, 2'd0, 2'b00);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
